// File: rtl/unified_mem_responder.sv
// Single-port word memory shared by an instruction-fetch and a data port, 2-cycle responses.
// Optional build macro MISALIGN_ERR_EN: misaligned data half/word accesses report d_err.
module unified_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 64
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    input  logic [1:0]  d_size_i,
    input  logic        d_unsigned_i,
    output logic        d_gnt_o,
    output logic        d_rvalid_o,
    output logic [31:0] d_rdata_o,
    output logic        d_err_o,
    output logic        busy_o
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e        state_q, state_d;
    logic [1:0]    dcnt_q, dcnt_d;
    logic          is_d_q, we_q, uns_q;
    logic [AW+1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [1:0]    size_q;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    logic [31:0]   mem_q [DEPTH_WORDS];

    logic          can_grant, d_win, d_gnt, if_gnt;
    logic [AW-1:0] idx;
    logic [31:0]   word, shifted, load_v, lanes, merged;
    logic [15:0]   half;
    logic [3:0]    wmask;
    logic          misalign, do_write;

    // Upper address bits wrap around and are intentionally dropped.
    logic unused_addr;
    assign unused_addr = ^{if_addr_i[31:AW+2], d_addr_i[31:AW+2]};

    always_comb begin
        can_grant = reset_ni && (state_q == StIdle || state_q == StResp);
        // Data wins unless it already took two grants in a row over a waiting fetch.
        d_win     = d_req_i && (!if_req_i || dcnt_q < 2'd2);
        d_gnt     = can_grant && d_win;
        if_gnt    = can_grant && if_req_i && !d_win;
    end

    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        unique case (state_q)
            StIdle, StResp: state_d = (d_gnt || if_gnt) ? StAccess : StIdle;
            StAccess:       state_d = StResp;
            default:        state_d = StIdle;
        endcase
        if (if_gnt) begin
            dcnt_d = 2'd0;
        end else if (d_gnt) begin
            dcnt_d = !if_req_i ? 2'd0 : (dcnt_q == 2'd2) ? 2'd2 : dcnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= StIdle;
            dcnt_q  <= 2'd0;
            is_d_q  <= 1'b0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= 2'd0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            if (d_gnt) begin
                is_d_q  <= 1'b1;
                we_q    <= d_we_i;
                uns_q   <= d_unsigned_i;
                addr_q  <= d_addr_i[AW+1:0];
                wdata_q <= d_wdata_i;
                size_q  <= d_size_i;
            end else if (if_gnt) begin
                is_d_q  <= 1'b0;
                we_q    <= 1'b0;
                uns_q   <= 1'b0;
                addr_q  <= if_addr_i[AW+1:0];
                wdata_q <= '0;
                size_q  <= 2'd2;
            end
            if (state_q == StAccess) begin
                rdata_q <= rdata_d;
                err_q   <= err_d;
            end
        end
    end

    always_comb begin
        idx     = addr_q[AW+1:2];
        word    = mem_q[idx];
        shifted = word >> {addr_q[1:0], 3'b000};
        half    = addr_q[1] ? word[31:16] : word[15:0];
`ifdef MISALIGN_ERR_EN
        misalign = is_d_q && (((size_q == 2'd1) && addr_q[0]) ||
                              (size_q[1] && (addr_q[1:0] != 2'd0)));
`else
        misalign = 1'b0;
`endif
        unique case (size_q)
            2'd0:    load_v = uns_q ? {24'd0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
            2'd1:    load_v = uns_q ? {16'd0, half} : {{16{half[15]}}, half};
            default: load_v = word;
        endcase
        unique case (size_q)
            2'd0: begin
                wmask = 4'b0001 << addr_q[1:0];
                lanes = {4{wdata_q[7:0]}};
            end
            2'd1: begin
                wmask = addr_q[1] ? 4'b1100 : 4'b0011;
                lanes = {2{wdata_q[15:0]}};
            end
            default: begin
                wmask = 4'b1111;
                lanes = wdata_q;
            end
        endcase
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = wmask[i] ? lanes[8*i +: 8] : word[8*i +: 8];
        end
        do_write = (state_q == StAccess) && is_d_q && we_q && !misalign;
        if (!is_d_q) begin
            rdata_d = word;
        end else if (misalign || we_q) begin
            rdata_d = '0;
        end else begin
            rdata_d = load_v;
        end
        err_d = misalign;
    end

    // Array has no reset; reset holds the FSM out of StAccess so no write can occur.
    always_ff @(posedge clk_i) begin
        if (do_write) begin
            mem_q[idx] <= merged;
        end
    end

    always_comb begin
        if_gnt_o    = if_gnt;
        d_gnt_o     = d_gnt;
        if_rvalid_o = (state_q == StResp) && !is_d_q;
        d_rvalid_o  = (state_q == StResp) && is_d_q;
        if_rdata_o  = if_rvalid_o ? rdata_q : '0;
        d_rdata_o   = d_rvalid_o ? rdata_q : '0;
        d_err_o     = d_rvalid_o && err_q;
        busy_o      = (state_q != StIdle);
    end

endmodule

// File: tb/tb_unified_mem_responder.sv
// Directed vector bench for unified_mem_responder: table of transactions plus
// arbitration and mid-transaction reset sequences.
module tb_unified_mem_responder;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        if_req, if_gnt, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_unsigned, d_gnt, d_rvalid, d_err, busy;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [1:0]  d_size;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    unified_mem_responder #(.DEPTH_WORDS(64)) dut (
        .clk_i        (clk),
        .reset_ni     (reset_n),
        .if_req_i     (if_req),
        .if_addr_i    (if_addr),
        .if_gnt_o     (if_gnt),
        .if_rvalid_o  (if_rvalid),
        .if_rdata_o   (if_rdata),
        .d_req_i      (d_req),
        .d_we_i       (d_we),
        .d_addr_i     (d_addr),
        .d_wdata_i    (d_wdata),
        .d_size_i     (d_size),
        .d_unsigned_i (d_unsigned),
        .d_gnt_o      (d_gnt),
        .d_rvalid_o   (d_rvalid),
        .d_rdata_o    (d_rdata),
        .d_err_o      (d_err),
        .busy_o       (busy)
    );

    typedef struct {
        logic        d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] exp_rdata;
        logic        exp_err;
        string       name;
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic all_outs_or();
        return |{if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, d_err, busy};
    endfunction

    // Called at #1 after a rising edge with the FSM idle.
    task automatic do_req(input vec_t v);
        logic got;
        got        = 1'b0;
        d_req      = v.d;
        if_req     = !v.d;
        d_we       = v.we;
        d_addr     = v.addr;
        if_addr    = v.addr;
        d_wdata    = v.wdata;
        d_size     = v.size;
        d_unsigned = v.uns;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (v.d ? d_gnt : if_gnt) begin
                got = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk({v.name, " grant"}, {31'd0, got}, 32'd1);
        if (!got) begin
            d_req  = 1'b0;
            if_req = 1'b0;
            @(posedge clk); #1;
            return;
        end
        chk({v.name, " other grant"}, {31'd0, v.d ? if_gnt : d_gnt}, 32'd0);
        @(posedge clk); #1;
        d_req  = 1'b0;
        if_req = 1'b0;
        @(negedge clk);
        chk({v.name, " access rvalid/busy"}, {29'd0, d_rvalid, if_rvalid, busy}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk({v.name, " resp rvalid"}, {30'd0, d_rvalid, if_rvalid}, v.d ? 32'd2 : 32'd1);
        chk({v.name, " rdata"}, v.d ? d_rdata : if_rdata, v.exp_rdata);
        chk({v.name, " err"}, {31'd0, d_err}, {31'd0, v.exp_err});
        @(posedge clk); #1;
        chk({v.name, " back to idle"}, {29'd0, busy, d_rvalid, if_rvalid}, 32'd0);
    endtask

    initial begin
        string order;
        int    d_rv, i_rv, both;
        logic  [31:0] exp22;
        logic         err22;
`ifdef MISALIGN_ERR_EN
        exp22 = 32'h0;
        err22 = 1'b1;
`else
        exp22 = 32'hCAFEF00D;
        err22 = 1'b0;
`endif
        //           d     we    addr          wdata         sz    uns   exp            err
        vecs[0]  = '{1'b1, 1'b1, 32'h10,  32'hDEADBEEF, 2'd2, 1'b0, 32'h0,        1'b0, "st w 10"};
        vecs[1]  = '{1'b1, 1'b0, 32'h10,  32'h0,        2'd2, 1'b0, 32'hDEADBEEF, 1'b0, "ld w 10"};
        vecs[2]  = '{1'b1, 1'b1, 32'h13,  32'h80,       2'd0, 1'b0, 32'h0,        1'b0, "st b 13"};
        vecs[3]  = '{1'b1, 1'b0, 32'h13,  32'h0,        2'd0, 1'b0, 32'hFFFFFF80, 1'b0, "ld b 13 s"};
        vecs[4]  = '{1'b1, 1'b0, 32'h13,  32'h0,        2'd0, 1'b1, 32'h00000080, 1'b0, "ld b 13 u"};
        vecs[5]  = '{1'b1, 1'b0, 32'h10,  32'h0,        2'd2, 1'b0, 32'h80ADBEEF, 1'b0, "ld w 10 b"};
        vecs[6]  = '{1'b1, 1'b1, 32'h04,  32'h11223344, 2'd3, 1'b0, 32'h0,        1'b0, "st w 04"};
        vecs[7]  = '{1'b1, 1'b0, 32'h104, 32'h0,        2'd2, 1'b0, 32'h11223344, 1'b0, "ld w 104"};
        vecs[8]  = '{1'b0, 1'b0, 32'h10,  32'h0,        2'd2, 1'b0, 32'h80ADBEEF, 1'b0, "if 10"};
        vecs[9]  = '{1'b1, 1'b0, 32'h12,  32'h0,        2'd1, 1'b0, 32'hFFFF80AD, 1'b0, "ld h 12 s"};
        vecs[10] = '{1'b1, 1'b0, 32'h10,  32'h0,        2'd1, 1'b1, 32'h0000BEEF, 1'b0, "ld h 10 u"};
        vecs[11] = '{1'b1, 1'b1, 32'h06,  32'hAAAA5555, 2'd1, 1'b0, 32'h0,        1'b0, "st h 06"};
        vecs[12] = '{1'b1, 1'b0, 32'h04,  32'h0,        2'd2, 1'b0, 32'h55553344, 1'b0, "ld w 04"};
        vecs[13] = '{1'b1, 1'b0, 32'h05,  32'h0,        2'd0, 1'b0, 32'h00000033, 1'b0, "ld b 05"};
        vecs[14] = '{1'b0, 1'b0, 32'h07,  32'h0,        2'd2, 1'b0, 32'h55553344, 1'b0, "if 07"};
        vecs[15] = '{1'b1, 1'b1, 32'h20,  32'hCAFEF00D, 2'd2, 1'b0, 32'h0,        1'b0, "st w 20"};
        vecs[16] = '{1'b1, 1'b0, 32'h22,  32'h0,        2'd2, 1'b0, exp22,        err22, "ld w 22"};

        reset_n = 1'b0;
        if_req = 1'b1; if_addr = 32'h0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
        d_size = 2'd2; d_unsigned = 1'b0;
        #12;
        chk("outputs in reset", {31'd0, all_outs_or()}, 32'd0);
        if_req = 1'b0;
        d_req  = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 17; v++) begin
            do_req(vecs[v]);
        end

        // Both ports requesting continuously: expect D,D,I,D,D,I.
        order = ""; d_rv = 0; i_rv = 0; both = 0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10; d_size = 2'd2; d_unsigned = 1'b0;
        if_req = 1'b1; if_addr = 32'h04;
        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            if (d_gnt && if_gnt) both++;
            if (d_gnt) order = {order, "D"};
            if (if_gnt) order = {order, "I"};
            if (d_rvalid) begin
                d_rv++;
                chk("arb d rdata", d_rdata, 32'h80ADBEEF);
            end
            if (if_rvalid) begin
                i_rv++;
                chk("arb if rdata", if_rdata, 32'h55553344);
            end
            @(posedge clk); #1;
            if (c == 11) begin
                d_req  = 1'b0;
                if_req = 1'b0;
            end
        end
        checks++;
        if (order != "DDIDDI") begin
            errors++;
            $display("FAIL arb order: got %s expected DDIDDI", order);
        end
        chk("arb d rvalids", d_rv, 32'd4);
        chk("arb if rvalids", i_rv, 32'd2);
        chk("arb dual grant", both, 32'd0);

        // Reset during ACCESS of a store, before the ACCESS edge.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h12345678; d_size = 2'd2;
        @(negedge clk);
        chk("rst store grant", {31'd0, d_gnt}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("outputs mid reset", {31'd0, all_outs_or()}, 32'd0);
        @(posedge clk); #1;
        chk("outputs held reset", {31'd0, all_outs_or()}, 32'd0);
        d_req = 1'b0;
        d_we  = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        d_rv = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (d_rvalid || if_rvalid || busy) d_rv++;
        end
        chk("no resp after reset", d_rv, 32'd0);
        @(posedge clk); #1;
        do_req('{1'b1, 1'b0, 32'h20, 32'h0, 2'd2, 1'b0, 32'hCAFEF00D, 1'b0, "ld w 20 post rst"});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/unified_mem_responder.md
UNIFIED_MEM_RESPONDER -- requirements
Module: unified_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 64, giving the number of 32-bit words in the array; index width AW = log2(DEPTH_WORDS).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports if_req input 1, if_addr input 32: instruction-fetch request and byte address.
REQ-005 SHALL have ports if_gnt output 1, if_rvalid output 1, if_rdata output 32: fetch grant, response valid, response word.
REQ-006 SHALL have ports d_req input 1, d_we input 1, d_addr input 32, d_wdata input 32: data request, write enable, byte address, store data.
REQ-007 SHALL have ports d_size input 2 (00 byte, 01 half, 10 word, 11 treated as word) and d_unsigned input 1 (zero-extend loads).
REQ-008 SHALL have ports d_gnt output 1, d_rvalid output 1, d_rdata output 32, d_err output 1: data grant, response valid, load data, error flag.
REQ-009 SHALL have port busy output 1, high whenever the FSM is not IDLE.

Function
REQ-010 SHALL implement the FSM states IDLE, ACCESS and RESP.
REQ-011 SHALL make if_gnt and d_gnt combinational, asserted only in IDLE or RESP, with at most one grant high per cycle.
REQ-012 SHALL, on a grant, capture the request fields on that edge and enter ACCESS; with no grant, RESP returns to IDLE and IDLE holds.
REQ-013 SHALL, in ACCESS, read or write the array at word index addr[AW+1:2], ignoring upper address bits (wrap-around), register the result, then enter RESP.
REQ-014 SHALL assert the granted port's rvalid for exactly one cycle in RESP; the response follows its grant by exactly 2 cycles; rdata is 0 whenever rvalid is low.
REQ-015 SHALL allow a new grant in RESP (back-to-back), giving a throughput of one transaction per 2 cycles.
REQ-016 SHALL arbitrate simultaneous requests in favour of data, except that fetch wins after two consecutive data grants while if_req was pending; the counter clears on any fetch grant.
REQ-017 SHALL write a store on the ACCESS edge only:
- byte to lane addr[1:0]
- half to lanes selected by addr[1]
- word to all lanes
- other lanes unchanged
REQ-018 SHALL return loads right-aligned, sign-extended unless d_unsigned is high; fetches always return the full word.
REQ-019 SHALL acknowledge a store with d_rvalid=1 and d_rdata=0.
REQ-020 SHALL make a load in the transaction after a store to the same word return the updated data.

Reset
REQ-021 SHALL, while reset is low, force state IDLE, zero the arbitration counter and drive every output to 0.
REQ-022 SHALL drop any transaction in flight when reset asserts mid-operation: no rvalid, and no array write unless the ACCESS edge already occurred.
REQ-023 SHALL not clear the array contents on reset.

Configuration
REQ-024 SHALL, with MISALIGN_ERR_EN defined, treat a data half access with addr[0]=1, or a word access with addr[1:0]!=0, as an error: no array write, d_rvalid=1, d_err=1, d_rdata=0.
REQ-025 SHALL, without MISALIGN_ERR_EN, ignore the misaligning low address bits and tie d_err to 0; fetch low bits are ignored in both builds.

Verification
REQ-026 SHALL cover: store word 0xDEADBEEF at 0x10, then load word 0x10 -> d_rvalid 2 cycles after grant, d_rdata=0xDEADBEEF.
REQ-027 SHALL cover: store byte 0x80 at 0x13, then load byte signed and unsigned at 0x13 -> 0xFFFFFF80, then 0x00000080; word at 0x10 reads 0x80ADBEEF.
REQ-028 SHALL cover: if_req and d_req held high for 6 grants -> grant order D,D,I,D,D,I; one rvalid per grant.
REQ-029 SHALL cover: load word 0x104 with DEPTH_WORDS=64 -> returns the word at 0x04 (wrap-around).
REQ-030 SHALL cover: reset pulsed low during ACCESS of a store of 0x12345678 to 0x20 -> no rvalid, all outputs 0; word 0x20 unchanged if reset arrived before the ACCESS edge.
REQ-031 SHALL cover: word load at 0x22 -> with MISALIGN_ERR_EN, d_err=1 and d_rdata=0; without it, the word at 0x20 is returned with d_err=0.
